// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Two-requester arbiter (instruction fetch, load/store) sharing a single
//   memory request/response bus. At most one transaction is outstanding.
//   The FSM moves through IDLE (grant), REQ (present the captured request
//   until accepted) and RESP (wait for and forward the single response).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_req_*               instruction read request (valid/addr/ready)
//   inst_resp_*              instruction read response (valid/data)
//   data_req_*               load/store request (valid/write/addr/wdata/strobe/ready)
//   data_resp_*              load data or store acknowledge (valid/rdata)
//   bus_req_*                shared memory request (valid/ready/write/addr/wdata/strobe)
//   bus_resp_*               shared memory response (valid/data)
//   busy                     transaction in flight (state != IDLE)
//   protocol_err             sticky: response seen outside RESP
module bus_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  inst_req_valid,
  input  logic [ADDR_WIDTH-1:0] inst_req_addr,
  output logic                  inst_req_ready,
  output logic                  inst_resp_valid,
  output logic [DATA_WIDTH-1:0] inst_resp_data,

  input  logic                  data_req_valid,
  input  logic                  data_req_write,
  input  logic [ADDR_WIDTH-1:0] data_req_addr,
  input  logic [DATA_WIDTH-1:0] data_req_wdata,
  input  logic [STRB_WIDTH-1:0] data_req_strobe,
  output logic                  data_req_ready,
  output logic                  data_resp_valid,
  output logic [DATA_WIDTH-1:0] data_resp_rdata,

  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic                  bus_req_write,
  output logic [ADDR_WIDTH-1:0] bus_req_addr,
  output logic [DATA_WIDTH-1:0] bus_req_wdata,
  output logic [STRB_WIDTH-1:0] bus_req_strobe,
  input  logic                  bus_resp_valid,
  input  logic [DATA_WIDTH-1:0] bus_resp_data,

  output logic                  busy,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_e;

  typedef enum logic {
    OWN_INST,
    OWN_DATA
  } owner_e;

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  owner_e                  last_grant_q, last_grant_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strobe_q, strobe_d;
  logic                    perr_q, perr_d;

  // Round-robin: under contention the requester not granted last wins.
  logic grant_inst, grant_data;
  assign grant_inst = inst_req_valid && (!data_req_valid || (last_grant_q == OWN_DATA));
  assign grant_data = data_req_valid && (!inst_req_valid || (last_grant_q == OWN_INST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_DATA;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strobe_q     <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strobe_q     <= strobe_d;
      perr_q       <= perr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    write_d         = write_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    strobe_d        = strobe_q;
    perr_d          = perr_q;

    inst_req_ready  = 1'b0;
    data_req_ready  = 1'b0;
    inst_resp_valid = 1'b0;
    inst_resp_data  = '0;
    data_resp_valid = 1'b0;
    data_resp_rdata = '0;
    bus_req_valid   = 1'b0;
    bus_req_write   = 1'b0;
    bus_req_addr    = '0;
    bus_req_wdata   = '0;
    bus_req_strobe  = '0;
    busy            = (state_q != S_IDLE);
    protocol_err    = perr_q;

    // A response is only legitimate while waiting in RESP.
    if (bus_resp_valid && (state_q != S_RESP)) begin
      perr_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (grant_inst) begin
          inst_req_ready = 1'b1;
          addr_d         = inst_req_addr;
          write_d        = 1'b0;
          wdata_d        = '0;
          strobe_d       = '0;
          owner_d        = OWN_INST;
          last_grant_d   = OWN_INST;
          state_d        = S_REQ;
        end else if (grant_data) begin
          data_req_ready = 1'b1;
          addr_d         = data_req_addr;
          write_d        = data_req_write;
          wdata_d        = data_req_wdata;
          strobe_d       = data_req_strobe;
          owner_d        = OWN_DATA;
          last_grant_d   = OWN_DATA;
          state_d        = S_REQ;
        end
      end

      S_REQ: begin
        bus_req_valid  = 1'b1;
        bus_req_write  = write_q;
        bus_req_addr   = addr_q;
        bus_req_wdata  = wdata_q;
        bus_req_strobe = strobe_q;
        if (bus_req_ready) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (bus_resp_valid) begin
          if (owner_q == OWN_INST) begin
            inst_resp_valid = 1'b1;
            inst_resp_data  = bus_resp_data;
          end else begin
            data_resp_valid = 1'b1;
            data_resp_rdata = bus_resp_data;
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet for the whole reset cycle, regardless of the
    // (possibly stale) registered state.
    if (rst) begin
      inst_req_ready  = 1'b0;
      data_req_ready  = 1'b0;
      inst_resp_valid = 1'b0;
      inst_resp_data  = '0;
      data_resp_valid = 1'b0;
      data_resp_rdata = '0;
      bus_req_valid   = 1'b0;
      bus_req_write   = 1'b0;
      bus_req_addr    = '0;
      bus_req_wdata   = '0;
      bus_req_strobe  = '0;
      busy            = 1'b0;
      protocol_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          inst_req_valid, inst_req_ready, inst_resp_valid;
  logic [AW-1:0] inst_req_addr;
  logic [DW-1:0] inst_resp_data;
  logic          data_req_valid, data_req_write, data_req_ready, data_resp_valid;
  logic [AW-1:0] data_req_addr;
  logic [DW-1:0] data_req_wdata, data_resp_rdata;
  logic [SW-1:0] data_req_strobe;
  logic          bus_req_valid, bus_req_ready, bus_req_write, bus_resp_valid;
  logic [AW-1:0] bus_req_addr;
  logic [DW-1:0] bus_req_wdata, bus_resp_data;
  logic [SW-1:0] bus_req_strobe;
  logic          busy, protocol_err;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .inst_req_valid(inst_req_valid), .inst_req_addr(inst_req_addr),
    .inst_req_ready(inst_req_ready), .inst_resp_valid(inst_resp_valid),
    .inst_resp_data(inst_resp_data),
    .data_req_valid(data_req_valid), .data_req_write(data_req_write),
    .data_req_addr(data_req_addr), .data_req_wdata(data_req_wdata),
    .data_req_strobe(data_req_strobe), .data_req_ready(data_req_ready),
    .data_resp_valid(data_resp_valid), .data_resp_rdata(data_resp_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write), .bus_req_addr(bus_req_addr),
    .bus_req_wdata(bus_req_wdata), .bus_req_strobe(bus_req_strobe),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .busy(busy), .protocol_err(protocol_err)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          is_data;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          rdy_dly;
    int          resp_dly;
    logic [31:0] rdata;
    logic        exp_wr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs[4];

  // One complete single-requester transaction with cycle-by-cycle checks.
  task automatic run_txn(input vec_t v, input logic exp_perr);
    if (v.is_data) begin
      data_req_valid = 1'b1; data_req_write = v.wr; data_req_addr = v.addr;
      data_req_wdata = v.wdata; data_req_strobe = v.strb;
      inst_req_valid = 1'b0; inst_req_addr = ~v.addr;
    end else begin
      inst_req_valid = 1'b1; inst_req_addr = v.addr;
      data_req_valid = 1'b0; data_req_write = 1'b1; data_req_addr = 32'hFFFF_0000;
      data_req_wdata = v.wdata; data_req_strobe = v.strb;
    end
    #1;
    chk("grant_inst_ready", inst_req_ready, !v.is_data);
    chk("grant_data_ready", data_req_ready, v.is_data);
    chk("grant_bus_valid", bus_req_valid, 0);
    chk("grant_busy", busy, 0);
    tick();
    // Requester withdraws and scribbles its lines: captured request must hold.
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    inst_req_addr = 32'h5555_5555; data_req_addr = 32'hAAAA_AAAA;
    data_req_wdata = 32'h0F0F_0F0F; data_req_strobe = 4'h5; data_req_write = ~v.wr;
    for (int i = 0; i <= v.rdy_dly; i++) begin
      bus_req_ready = (i == v.rdy_dly);
      #1;
      chk("req_valid", bus_req_valid, 1);
      chk("req_addr", bus_req_addr, v.addr);
      chk("req_write", bus_req_write, v.exp_wr);
      chk("req_wdata", bus_req_wdata, v.exp_wdata);
      chk("req_strobe", bus_req_strobe, v.exp_strb);
      chk("req_readies", {inst_req_ready, data_req_ready}, 0);
      chk("req_busy", busy, 1);
      tick();
    end
    bus_req_ready = 1'b0;
    for (int i = 0; i <= v.resp_dly; i++) begin
      bus_resp_valid = (i == v.resp_dly);
      bus_resp_data  = (i == v.resp_dly) ? v.rdata : 32'hBAD0_0000;
      #1;
      chk("resp_bus_valid", bus_req_valid, 0);
      chk("resp_inst_valid", inst_resp_valid, (i == v.resp_dly) && !v.is_data);
      chk("resp_data_valid", data_resp_valid, (i == v.resp_dly) && v.is_data);
      chk("resp_inst_data", inst_resp_data,
          ((i == v.resp_dly) && !v.is_data) ? v.rdata : 32'h0);
      chk("resp_data_rdata", data_resp_rdata,
          ((i == v.resp_dly) && v.is_data) ? v.rdata : 32'h0);
      tick();
    end
    bus_resp_valid = 1'b0; bus_resp_data = '0;
    #1;
    chk("after_busy", busy, 0);
    chk("after_resp_valids", {inst_resp_valid, data_resp_valid}, 0);
    chk("after_perr", protocol_err, exp_perr);
  endtask

  // Both requesters valid in IDLE; exp_data selects the expected winner.
  task automatic contend(input bit exp_data, input logic [31:0] rdata);
    inst_req_valid = 1'b1; inst_req_addr = 32'h0000_00A0;
    data_req_valid = 1'b1; data_req_write = 1'b0; data_req_addr = 32'h0000_00B0;
    data_req_wdata = '0; data_req_strobe = '0;
    #1;
    chk("cont_inst_ready", inst_req_ready, !exp_data);
    chk("cont_data_ready", data_req_ready, exp_data);
    tick();
    bus_req_ready = 1'b1;
    #1;
    chk("cont_addr", bus_req_addr, exp_data ? 32'hB0 : 32'hA0);
    chk("cont_req_readies", {inst_req_ready, data_req_ready}, 0);
    tick();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = rdata;
    #1;
    chk("cont_inst_resp", inst_resp_valid, !exp_data);
    chk("cont_data_resp", data_resp_valid, exp_data);
    tick();
    bus_resp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 0, 32'h0000_0100, 32'h1111_2222, 4'hC, 0, 0, 32'h0000_0513, 0, 32'h0, 4'h0};
    vecs[1] = '{1, 1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 3, 0, 32'h0, 1, 32'hDEAD_BEEF, 4'hF};
    vecs[2] = '{1, 0, 32'h0000_3004, 32'h0, 4'h0, 0, 2, 32'h1234_5678, 0, 32'h0, 4'h0};
    vecs[3] = '{1, 1, 32'h0000_4008, 32'h00C0_FFEE, 4'h3, 1, 1, 32'h0, 1, 32'h00C0_FFEE, 4'h3};

    rst = 1'b1;
    inst_req_valid = 1'b1; inst_req_addr = 32'h40;
    data_req_valid = 1'b1; data_req_write = 1'b1; data_req_addr = 32'h80;
    data_req_wdata = 32'h1; data_req_strobe = 4'hF;
    bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_resp_data = 32'h99;
    #1;
    chk("rst_readies", {inst_req_ready, data_req_ready}, 0);
    tick();
    chk("rst_outputs", {inst_req_ready, data_req_ready, inst_resp_valid, data_resp_valid,
                        bus_req_valid, busy, protocol_err}, 0);
    chk("rst_bus_addr", bus_req_addr, 0);
    tick();
    rst = 1'b0;
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = '0;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_perr", protocol_err, 0);

    // Contention after reset: INST, DATA, INST.
    contend(0, 32'h11);
    contend(1, 32'h22);
    contend(0, 32'h33);
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    #1;
    chk("cont_done_busy", busy, 0);

    for (int i = 0; i < 4; i++) run_txn(vecs[i], 1'b0);

    // Unexpected response in IDLE.
    bus_resp_valid = 1'b1; bus_resp_data = 32'hCAFE;
    #1;
    chk("unexp_resp_valids", {inst_resp_valid, data_resp_valid}, 0);
    chk("unexp_resp_data", {inst_resp_data, data_resp_rdata}, 0);
    tick();
    bus_resp_valid = 1'b0;
    #1;
    chk("unexp_perr_set", protocol_err, 1);
    tick(); tick(); tick();
    chk("unexp_perr_sticky", protocol_err, 1);
    run_txn(vecs[2], 1'b1);
    do_reset();
    #1;
    chk("perr_cleared", protocol_err, 0);

    // Response in the cycle the request is accepted is not a response.
    inst_req_valid = 1'b1; inst_req_addr = 32'h300;
    tick();
    inst_req_valid = 1'b0; bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_resp_data = 32'h999;
    #1;
    chk("early_resp_fwd", inst_resp_valid, 0);
    tick();
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    #1;
    chk("early_resp_perr", protocol_err, 1);
    chk("early_resp_busy", busy, 1);
    bus_resp_valid = 1'b1; bus_resp_data = 32'h444;
    #1;
    chk("late_ok_valid", inst_resp_valid, 1);
    chk("late_ok_data", inst_resp_data, 32'h444);
    tick();
    bus_resp_valid = 1'b0;
    do_reset();

    // Reset while waiting in RESP.
    inst_req_valid = 1'b1; inst_req_addr = 32'h200;
    tick();
    inst_req_valid = 1'b0; bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    #1;
    chk("midrst_in_resp", busy, 1);
    rst = 1'b1; bus_resp_valid = 1'b1; bus_resp_data = 32'h77;
    #1;
    chk("midrst_outputs", {inst_resp_valid, data_resp_valid, bus_req_valid, busy, protocol_err}, 0);
    chk("midrst_data", inst_resp_data, 0);
    tick();
    rst = 1'b0; bus_resp_valid = 1'b0;
    #1;
    chk("midrst_idle", busy, 0);
    chk("midrst_perr", protocol_err, 0);
    bus_resp_valid = 1'b1;
    #1;
    chk("midrst_late_fwd", inst_resp_valid, 0);
    tick();
    bus_resp_valid = 1'b0;
    #1;
    chk("midrst_late_perr", protocol_err, 1);
    do_reset();
    run_txn(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
